hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed load-use hazard and forwarding logic of the 5-stage core.
- Tracks in-flight register writers in a shift-register scoreboard covering EX..WB.
- Produces the stall and bubble controls for ID and the registered forwarding selects for EX.
- Generalises to any post-ID depth and any per-instruction result latency. Adds branch flush and a stall performance counter.

---
 rtl/hz_pkg.sv | 23 ++
 rtl/hz_src_match.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared definitions for the hazard scoreboard: default geometry, the
// forwarding-select encoding for "no forward" and the per-slot record.
package hz_pkg;

    localparam int HZ_NREGS   = 32;
    localparam int HZ_RAW     = 5;
    localparam int HZ_DEPTH   = 3;
    localparam int HZ_LW      = 2;
    localparam int HZ_FLUSH_N = 1;
    localparam int HZ_CW      = 16;

    // Forwarding select value meaning "take the operand from the regfile".
    localparam logic [HZ_LW-1:0] FWD_REGFILE = {HZ_LW{1'b0}};

    // One in-flight writer: whether it is tracked, its destination and
    // how many stages after EX its result becomes available.
    typedef struct packed {
        logic              valid;
        logic [HZ_RAW-1:0] rd;
        logic [HZ_LW-1:0]  lat;
    } slot_t;

endpackage

// File: rtl/hz_src_match.sv
// Priority search of the forwardable scoreboard slots for one source
// register. The youngest (lowest index) matching writer wins. Register 0
// never matches. A hazard exists when the winning writer's result is not
// yet available by the time the consumer reaches EX.
module hz_src_match #(
    parameter int DEPTH = 3,
    parameter int RAW   = 5,
    parameter int LW    = 2
) (
    input  logic [RAW-1:0]            src,
    input  logic                      srcUsed,
    input  logic [DEPTH-2:0]          slotValid,
    input  logic [(DEPTH-1)*RAW-1:0]  slotRd,
    input  logic [(DEPTH-1)*LW-1:0]   slotLat,
    output logic                      hit,
    output logic [LW-1:0]             idx,
    output logic                      hazard
);

    logic [DEPTH-2:0] matchVec_s;
    logic [LW-1:0]    latSel_s;

    // Per-slot compare, then walk from oldest to youngest so the youngest match overrides.
    always_comb begin
        matchVec_s = {(DEPTH-1){1'b0}};
        idx        = {LW{1'b0}};
        latSel_s   = {LW{1'b0}};
        for (int i = 0; i < DEPTH - 1; i++) begin
            matchVec_s[i] = slotValid[i]
                            && (slotRd[i*RAW +: RAW] == src)
                            && (src != {RAW{1'b0}});
        end
        for (int i = DEPTH - 2; i >= 0; i--) begin
            idx      = matchVec_s[i] ? LW'(i) : idx;
            latSel_s = matchVec_s[i] ? slotLat[i*LW +: LW] : latSel_s;
        end
        hit    = |matchVec_s;
        hazard = srcUsed && hit && (idx < latSel_s);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard detection and EX forwarding control. In-flight writers
// ride a shift register from EX (slot 0) to WB (slot DEPTH-1); ID compares
// its sources against the forwardable slots to decide whether to stall and
// which slot EX should forward from on the following cycle.
module hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int NREGS   = HZ_NREGS,
    parameter int RAW     = $clog2(NREGS),
    parameter int DEPTH   = HZ_DEPTH,
    parameter int LW      = $clog2(DEPTH),
    parameter int FLUSH_N = HZ_FLUSH_N,
    parameter int CW      = HZ_CW
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic           id_wr,
    input  logic [RAW-1:0] id_rd,
    input  logic [LW-1:0]  id_lat,
    input  logic           flush,
    output logic           pc_write,
    output logic           ifid_write,
    output logic           ctrl_bubble,
    output logic [LW-1:0]  ex_fwd_a,
    output logic [LW-1:0]  ex_fwd_b,
    output logic [CW-1:0]  stall_count
);

    localparam logic [LW-1:0] FWD_STEP  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_STEP  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    slot_t                   slots_r     [DEPTH];
    slot_t                   slotsNext_s [DEPTH];
    logic [DEPTH-2:0]        srchValid_s;
    logic [(DEPTH-1)*RAW-1:0] srchRd_s;
    logic [(DEPTH-1)*LW-1:0]  srchLat_s;

    logic          hitA_s, hitB_s;
    logic          hazA_s, hazB_s;
    logic [LW-1:0] idxA_s, idxB_s;
    logic          stall_s;
    logic          issue_s;
    logic [LW-1:0] fwdA_r, fwdB_r;
    logic [LW-1:0] fwdANext_s, fwdBNext_s;
    logic [CW-1:0] stallCount_r;

    // Flatten the forwardable slots (all but WB) for the source searches.
    always_comb begin
        srchValid_s = {(DEPTH-1){1'b0}};
        srchRd_s    = {((DEPTH-1)*RAW){1'b0}};
        srchLat_s   = {((DEPTH-1)*LW){1'b0}};
        for (int j = 0; j < DEPTH - 1; j++) begin
            srchValid_s[j]             = slots_r[j].valid;
            srchRd_s[j*RAW +: RAW]     = slots_r[j].rd;
            srchLat_s[j*LW +: LW]      = slots_r[j].lat;
        end
    end

    hz_src_match #(.DEPTH(DEPTH), .RAW(RAW), .LW(LW)) matchA (
        .src       (id_rs),
        .srcUsed   (id_use_rs),
        .slotValid (srchValid_s),
        .slotRd    (srchRd_s),
        .slotLat   (srchLat_s),
        .hit       (hitA_s),
        .idx       (idxA_s),
        .hazard    (hazA_s)
    );

    hz_src_match #(.DEPTH(DEPTH), .RAW(RAW), .LW(LW)) matchB (
        .src       (id_rt),
        .srcUsed   (id_use_rt),
        .slotValid (srchValid_s),
        .slotRd    (srchRd_s),
        .slotLat   (srchLat_s),
        .hit       (hitB_s),
        .idx       (idxB_s),
        .hazard    (hazB_s)
    );

    // Stall/issue decision; a flush overrides any stall and blocks issue.
    always_comb begin
        stall_s     = id_valid && (hazA_s || hazB_s) && !flush;
        issue_s     = id_valid && !stall_s && !flush;
        pc_write    = !stall_s;
        ifid_write  = !stall_s;
        ctrl_bubble = stall_s;
    end

    // Next scoreboard contents: issue or bubble into EX, shift the rest, kill flushed slots.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            slotsNext_s[j].valid = 1'b0;
            slotsNext_s[j].rd    = {RAW{1'b0}};
            slotsNext_s[j].lat   = {LW{1'b0}};
        end
        if (issue_s && id_wr && (id_rd != {RAW{1'b0}})) begin
            slotsNext_s[0].valid = 1'b1;
            slotsNext_s[0].rd    = id_rd;
            slotsNext_s[0].lat   = id_lat;
        end else begin
            slotsNext_s[0].valid = 1'b0;
        end
        for (int j = 1; j < DEPTH; j++) begin
            slotsNext_s[j].rd    = slots_r[j-1].rd;
            slotsNext_s[j].lat   = slots_r[j-1].lat;
            slotsNext_s[j].valid = slots_r[j-1].valid
                                   && !(flush && ((j - 1) < FLUSH_N));
        end
    end

    // Forwarding selects for the instruction entering EX; zero unless it actually issues.
    always_comb begin
        fwdANext_s = (issue_s && id_use_rs && hitA_s) ? (idxA_s + FWD_STEP) : FWD_REGFILE;
        fwdBNext_s = (issue_s && id_use_rt && hitB_s) ? (idxB_s + FWD_STEP) : FWD_REGFILE;
    end

    // State update: scoreboard shift, forwarding registers and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                slots_r[j].valid <= 1'b0;
                slots_r[j].rd    <= {RAW{1'b0}};
                slots_r[j].lat   <= {LW{1'b0}};
            end
            fwdA_r       <= FWD_REGFILE;
            fwdB_r       <= FWD_REGFILE;
            stallCount_r <= {CW{1'b0}};
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                slots_r[j] <= slotsNext_s[j];
            end
            fwdA_r <= fwdANext_s;
            fwdB_r <= fwdBNext_s;
            if (stall_s && (stallCount_r != CNT_MAX)) begin
                stallCount_r <= stallCount_r + CNT_STEP;
            end else begin
                stallCount_r <= stallCount_r;
            end
        end
    end

    assign ex_fwd_a    = fwdA_r;
    assign ex_fwd_b    = fwdB_r;
    assign stall_count = stallCount_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The counter is narrowed to 3 bits
// so saturation can be reached quickly.
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_use_rs, id_use_rt, id_wr, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] id_lat;
    logic       pc_write, ifid_write, ctrl_bubble;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic [2:0] stall_count;

    int checkCount = 0;
    int passCount  = 0;

    hazard_scoreboard #(.CW(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wr       (id_wr),
        .id_rd       (id_rd),
        .id_lat      (id_lat),
        .flush       (flush),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ctrl_bubble (ctrl_bubble),
        .ex_fwd_a    (ex_fwd_a),
        .ex_fwd_b    (ex_fwd_b),
        .stall_count (stall_count)
    );

    // Free-running core clock.
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs == exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Stall controls packed as {pc_write, ifid_write, ctrl_bubble}.
    task automatic checkStall(input string tag, input bit expStall);
        checkVal(tag, int'({pc_write, ifid_write, ctrl_bubble}),
                 expStall ? 1 : 6);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic ut, input logic wr,
                         input logic [4:0] rd, input logic [1:0] lat, input logic fl);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = ur;
        id_use_rt = ut;
        id_wr     = wr;
        id_rd     = rd;
        id_lat    = lat;
        flush     = fl;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        checkVal("rst_fwd_a", ex_fwd_a, 0);
        checkVal("rst_fwd_b", ex_fwd_b, 0);
        checkVal("rst_count", stall_count, 0);
        checkStall("rst_ctrl", 1'b0);
        reset = 1'b0;
        tick();

        // ALU writer then immediate reader: forward from EX slot.
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("alu_nostall", 1'b0);
        tick();
        checkVal("alu_fwd_a", ex_fwd_a, 1);
        checkVal("alu_fwd_b", ex_fwd_b, 0);
        idle(3);

        // Writer, independent instruction, then reader on rt: forward from MEM.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("gap_nostall", 1'b0);
        tick();
        checkVal("gap_fwd_b", ex_fwd_b, 2);
        checkVal("gap_fwd_a", ex_fwd_a, 0);
        idle(3);

        // Load-use: one stall, then forward from MEM.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("ld_stall", 1'b1);
        tick();
        checkVal("ld_count", stall_count, 1);
        checkVal("ld_fwd_during", ex_fwd_a, 0);
        checkStall("ld_release", 1'b0);
        tick();
        checkVal("ld_fwd_a", ex_fwd_a, 2);
        checkVal("ld_count_hold", stall_count, 1);
        idle(3);

        // Two writers of r7: youngest wins.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("young_nostall", 1'b0);
        tick();
        checkVal("young_fwd_a", ex_fwd_a, 1);
        idle(3);

        // Load to r0 never stalls nor forwards.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("r0_nostall", 1'b0);
        tick();
        checkVal("r0_fwd_a", ex_fwd_a, 0);
        checkVal("r0_fwd_b", ex_fwd_b, 0);
        idle(3);

        // Latency-2 writer: two stalls, then the writer is in WB (regfile).
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 2'd2, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("l2_stall_ex", 1'b1);
        tick();
        checkStall("l2_stall_mem", 1'b1);
        tick();
        checkStall("l2_release", 1'b0);
        tick();
        checkVal("l2_fwd_a", ex_fwd_a, 0);
        checkVal("l2_count", stall_count, 3);
        idle(3);

        // Flush during the load-use stall cycle kills the load in EX.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1);
        checkStall("fl_override", 1'b0);
        tick();
        checkVal("fl_fwd_a", ex_fwd_a, 0);
        checkVal("fl_count", stall_count, 3);
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        checkStall("fl_killed", 1'b0);
        tick();
        checkVal("fl_nofwd", ex_fwd_a, 0);
        idle(3);

        // Saturation: each latency-2 pair adds two stalls.
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 2'd2, 1'b0);
            tick();
            drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
            tick();
            tick();
            tick();
            if (p == 1) begin
                checkVal("sat_reach", stall_count, 7);
            end else begin
                checkVal("sat_progress", stall_count, (p == 0) ? 5 : 7);
            end
        end
        idle(3);

        // Reset with a load in flight clears the scoreboard and counter.
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0);
        reset = 1'b1;
        tick();
        checkVal("mrst_count", stall_count, 0);
        checkVal("mrst_fwd_a", ex_fwd_a, 0);
        reset = 1'b0;
        #1;
        checkStall("mrst_nostall", 1'b0);
        tick();
        checkVal("mrst_fwd_after", ex_fwd_a, 0);
        checkVal("mrst_count_after", stall_count, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
